// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer issuing one-cycle stage enables (INIT ARK, rounds 1..10).
// Optional macro AES_ROUND_CTRL_STALL_EN adds hold_i, which freezes sequencing outside IDLE.
// All outputs are registered copies of the current state decode, so they trail the state by one cycle.
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter int STAGE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef AES_ROUND_CTRL_STALL_EN
  input  logic       hold_i,
`endif
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       sel_init_o,
  output logic       sub_en_o,
  output logic       shift_en_o,
  output logic       mix_en_o,
  output logic       ark_en_o,
  output logic       key_step_o,
  output logic [3:0] round_o,
  output logic [7:0] rcon_o,
  output logic       busy_o
);
  typedef enum logic [2:0] {IDLE, INIT, SUB, SHIFT, MIX, ARK, DONE} state_t;
  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [1:0] LAST_CNT = 2'(STAGE_LAT - 1);
  state_t     r_state;
  logic [1:0] r_cnt;
  logic [3:0] r_round;
  logic [7:0] r_rcon;
  logic       w_hold, w_run, w_first, w_last, w_acc, w_hs;
`ifdef AES_ROUND_CTRL_STALL_EN
  assign w_hold = hold_i;
`else
  assign w_hold = 1'b0;
`endif
  assign w_run   = !w_hold || r_state == IDLE;
  assign w_first = w_run && r_cnt == 2'd0;
  assign w_last  = r_cnt == LAST_CNT;
  assign w_acc   = in_valid_i && in_ready_o;
  assign w_hs    = out_valid_o && out_ready_i && w_run;
  // Sequencer state, stage counter, round/rcon tracking and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_round     <= 4'd0;
      r_rcon      <= 8'h00;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      sel_init_o  <= 1'b0;
      sub_en_o    <= 1'b0;
      shift_en_o  <= 1'b0;
      mix_en_o    <= 1'b0;
      ark_en_o    <= 1'b0;
      key_step_o  <= 1'b0;
      round_o     <= 4'd0;
      rcon_o      <= 8'h00;
    end else begin
      in_ready_o  <= r_state == IDLE && !w_acc;
      out_valid_o <= r_state == DONE && !w_hs;
      busy_o      <= r_state != IDLE;
      sel_init_o  <= w_first && r_state == INIT;
      ark_en_o    <= w_first && (r_state == INIT || r_state == ARK);
      sub_en_o    <= w_first && r_state == SUB;
      key_step_o  <= w_first && r_state == SUB;
      shift_en_o  <= w_first && r_state == SHIFT;
      mix_en_o    <= w_first && r_state == MIX;
      round_o     <= r_round;
      rcon_o      <= r_rcon;
      if (w_run) begin
        if (r_state inside {INIT, SUB, SHIFT, MIX, ARK})
          r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
        case (r_state)
          IDLE:  if (w_acc) r_state <= INIT;
          INIT:  if (w_last) begin
                   r_state <= SUB;
                   r_round <= 4'd1;
                   r_rcon  <= 8'h01;
                 end
          SUB:   if (w_last) r_state <= SHIFT;
          SHIFT: if (w_last) r_state <= r_round == LAST_RND ? ARK : MIX;
          MIX:   if (w_last) r_state <= ARK;
          ARK:   if (w_last) begin
                   if (r_round == LAST_RND) r_state <= DONE;
                   else begin
                     r_state <= SUB;
                     r_round <= r_round + 4'd1;
                     r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                   end
                 end
          DONE:  if (w_hs) begin
                   r_state <= IDLE;
                   r_round <= 4'd0;
                   r_rcon  <= 8'h00;
                 end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl with STAGE_LAT=1 and STAGE_LAT=3 instances.
module tb_aes_round_ctrl;
  typedef struct {
    logic [6:0] ev;
    logic [3:0] round;
    logic [7:0] rcon;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       in_valid [2];
  logic       out_ready [2];
  logic       hold;
  logic       in_ready [2], out_valid [2], sel [2], sub [2], shf [2], mix [2], ark [2], key [2], busy [2];
  logic [3:0] rnd [2];
  logic [7:0] rcon [2];
  logic       ov_q [2];
  int         kc [2];
  exp_t       q [2][$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.NR(10), .STAGE_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n[0]),
`ifdef AES_ROUND_CTRL_STALL_EN
    .hold_i(hold),
`endif
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .sel_init_o(sel[0]), .sub_en_o(sub[0]), .shift_en_o(shf[0]), .mix_en_o(mix[0]), .ark_en_o(ark[0]),
    .key_step_o(key[0]), .round_o(rnd[0]), .rcon_o(rcon[0]), .busy_o(busy[0]));

  aes_round_ctrl #(.NR(10), .STAGE_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n[1]),
`ifdef AES_ROUND_CTRL_STALL_EN
    .hold_i(1'b0),
`endif
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .sel_init_o(sel[1]), .sub_en_o(sub[1]), .shift_en_o(shf[1]), .mix_en_o(mix[1]), .ark_en_o(ark[1]),
    .key_step_o(key[1]), .round_o(rnd[1]), .rcon_o(rcon[1]), .busy_o(busy[1]));

  // Monitor: every enable pulse or out_valid rise must match the head of that instance's queue.
  always @(negedge clk) begin
    logic [6:0] ev;
    exp_t       e;
    for (int d = 0; d < 2; d++) begin
      ev = {out_valid[d] & !ov_q[d], sel[d], sub[d], shf[d], mix[d], ark[d], key[d]};
      ov_q[d] = out_valid[d];
      if (ev != 7'd0) begin
        if (key[d]) kc[d]++;
        checks++;
        if (q[d].size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected d=%0d: got ev=%b round=%0d rcon=%h cyc=%0d, expected no event", d, ev, rnd[d], rcon[d], cyc);
        end else begin
          e = q[d].pop_front();
          if (ev !== e.ev || rnd[d] !== e.round || rcon[d] !== e.rcon || cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_event d=%0d: got ev=%b round=%0d rcon=%h cyc=%0d, expected ev=%b round=%0d rcon=%h cyc=%0d",
                     d, ev, rnd[d], rcon[d], cyc, e.ev, e.round, e.rcon, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] outs(input int d);
    return {busy[d], sel[d], sub[d], shf[d], mix[d], ark[d], key[d], out_valid[d], rnd[d], rcon[d]};
  endfunction

  task automatic push(input int d, input logic [6:0] ev, input logic [3:0] r, input logic [7:0] rc, input int c);
    exp_t e;
    e.ev = ev; e.round = r; e.rcon = rc; e.cyc = c;
    q[d].push_back(e);
  endtask

  function automatic int adj(input int e, input int h);
    return (h >= 0 && e >= h) ? e + 5 : e;
  endfunction

  // Expected trace for one block accepted at edge t: pulse k lands on edge t+1+k*L (shifted by a 5-cycle hold at h).
  task automatic load(input int d, input int t, input int L, input int h);
    int k;
    push(d, 7'b0100010, 4'd0, 8'h00, adj(t + 1, h));
    k = 1;
    for (int r = 1; r <= 10; r++) begin
      push(d, 7'b0010001, 4'(r), rc_tab[r-1], adj(t + 1 + k * L, h)); k++;
      push(d, 7'b0001000, 4'(r), rc_tab[r-1], adj(t + 1 + k * L, h)); k++;
      if (r < 10) begin
        push(d, 7'b0000100, 4'(r), rc_tab[r-1], adj(t + 1 + k * L, h)); k++;
      end
      push(d, 7'b0000010, 4'(r), rc_tab[r-1], adj(t + 1 + k * L, h)); k++;
    end
    push(d, 7'b1000000, 4'd10, 8'h36, adj(t + 1 + k * L, h));
  endtask

  task automatic run_block(input int d, input int hk);
    int L, t, h, k0;
    L = d ? 3 : 1;
    @(negedge clk);
    chk("ready_idle", 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1 t = cyc;
    h = hk >= 0 ? t + 1 + hk : -1;
    load(d, t, L, h);
    k0 = kc[d];
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("ready_drop", 32'(in_ready[d]), 32'd0);
`ifdef AES_ROUND_CTRL_STALL_EN
    if (h >= 0) begin
      while (cyc < h - 1) @(negedge clk);
      hold = 1'b1;
      while (cyc < h + 4) @(negedge clk);
      hold = 1'b0;
    end
`endif
    for (int i = 0; i < 50 * L && !out_valid[d]; i++) @(negedge clk);
    chk("done_timeout", 32'(out_valid[d]), 32'd1);
    repeat (7) begin
      @(negedge clk);
      chk("backpressure_valid", 32'(out_valid[d]), 32'd1);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("valid_drop", 32'(out_valid[d]), 32'd0);
    chk("ready_still_low", 32'(in_ready[d]), 32'd0);
    @(negedge clk);
    chk("ready_back", 32'(in_ready[d]), 32'd1);
    chk("idle_outs", 32'(outs(d)), 32'd0);
    chk("key_steps", 32'(kc[d] - k0), 32'd10);
    chk("sb_empty", 32'(q[d].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; ov_q[d] = 1'b0; kc[d] = 0;
    end
    hold = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs", 32'(outs(d)), 32'd0);
      chk("reset_ready", 32'(in_ready[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    run_block(0, -1);
    // Asynchronous reset between edges while round 5 MixColumns is being issued.
    @(negedge clk);
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 t = cyc;
    load(0, t, 1, -1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    while (cyc < t + 19) @(negedge clk);
    @(posedge clk);
    #1 chk("mix_r5_before_reset", 32'({mix[0], rnd[0]}), 32'h15);
    #1 rst_n[0] = 1'b0;
    q[0].delete();
    #1;
    chk("midreset_outs", 32'(outs(0)), 32'd0);
    chk("midreset_ready", 32'(in_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    run_block(0, -1);
`ifdef AES_ROUND_CTRL_STALL_EN
    run_block(0, 10);
`endif
    run_block(1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
